// File: rtl/gpu_apb_pkg.sv
// Shared types and GPU register map for the APB command master.
package gpu_apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] data;
        logic                  write;
    } apb_cmd_t;

    // GPU command register offsets on the APB slave port
    localparam logic [APB_ADDR_W-1:0] GPU_REG_CMD_X  = 32'h0000_0000;
    localparam logic [APB_ADDR_W-1:0] GPU_REG_CMD_Y  = 32'h0000_0004;
    localparam logic [APB_ADDR_W-1:0] GPU_REG_COLOR  = 32'h0000_0008;
    localparam logic [APB_ADDR_W-1:0] GPU_REG_OP     = 32'h0000_000C;
    localparam logic [APB_ADDR_W-1:0] GPU_REG_STATUS = 32'h0000_0010;

    // Reads drive zero on the write-data bus
    function automatic logic [APB_DATA_W-1:0] apb_wdata(input apb_cmd_t cmd);
        return cmd.write ? cmd.data : '0;
    endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO; head entry is presented combinationally.
module gpu_cmd_fifo
    import gpu_apb_pkg::*;
#(
    parameter int unsigned  FIFO_DEPTH = 4,
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  apb_cmd_t         push_data,
    input  logic             pop,
    output apb_cmd_t         head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    apb_cmd_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/gpu_apb_master.sv
// APB initiator feeding the GPU command port from a buffered valid/ready stream.
module gpu_apb_master
    import gpu_apb_pkg::*;
#(
    parameter int unsigned ADDR_W     = APB_ADDR_W,
    parameter int unsigned DATA_W     = APB_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    input  logic              cmd_write_i,
    input  logic              gpu_full_i,
    output logic [ADDR_W-1:0] pAddr_o,
    output logic [DATA_W-1:0] pDataWrite_o,
    output logic              pSel_o,
    output logic              pEnable_o,
    output logic              pWrite_o,
    output logic              busy_o,
    output logic [15:0]       xfer_count_o
);

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0]  S_IDLE   = 2'(IDLE);
    localparam logic [1:0]  S_SETUP  = 2'(SETUP);
    localparam logic [1:0]  S_ACCESS = 2'(ACCESS);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    apb_cmd_t         push_cmd;
    apb_cmd_t         head_cmd;

    assign fifo_push   = cmd_valid_i && !fifo_full;
    assign cmd_ready_o = !fifo_full;
    assign busy_o      = (fifo_count != '0) || (state_q != S_IDLE);
    assign push_cmd    = '{addr:  APB_ADDR_W'(cmd_addr_i),
                           data:  APB_DATA_W'(cmd_data_i),
                           write: cmd_write_i};

    gpu_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .head      (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next transfer may only start when the GPU has room
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !gpu_full_i) begin
                    state_d  = S_SETUP;
                    fifo_pop = 1'b1;
                end
            end
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (!fifo_empty && !gpu_full_i) begin
                    state_d  = S_SETUP;
                    fifo_pop = 1'b1;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // APB outputs; address/data/direction hold after the bus returns idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pAddr_o      <= '0;
            pDataWrite_o <= '0;
            pWrite_o     <= 1'b0;
            pSel_o       <= 1'b0;
            pEnable_o    <= 1'b0;
            xfer_count_o <= '0;
        end else begin
            if (fifo_pop) begin
                pAddr_o      <= ADDR_W'(head_cmd.addr);
                pDataWrite_o <= DATA_W'(apb_wdata(head_cmd));
                pWrite_o     <= head_cmd.write;
                pSel_o       <= 1'b1;
                pEnable_o    <= 1'b0;
            end else if (state_q == S_SETUP) begin
                pEnable_o    <= 1'b1;
            end else if (state_q == S_ACCESS) begin
                pSel_o       <= 1'b0;
                pEnable_o    <= 1'b0;
            end
            if (state_q == S_ACCESS) begin
                xfer_count_o <= xfer_count_o + 16'd1;
            end
        end
    end

endmodule

// File: doc/gpu_apb_master.md
Name: gpu_apb_master

Overview:
- APB initiator that drives the GPU's APB slave command port (pAddr/pDataWrite/pSel/pEnable/pWrite) from a host-side valid/ready command stream.
- Buffers commands in a small FIFO and issues APB setup/access pairs.
- Pauses issue while the GPU reports its command FIFO full (gpu_full_i, toggled by the GPU's full_change_irq).
- Sits between the host/CPU model and the gpu top; replaces hand-written APB stimulus in benches and SoC glue.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB write-data width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid_i  in  1  host command valid
cmd_ready_o  out  1  FIFO can accept (= !fifo_full)
cmd_addr_i  in  ADDR_W  command APB address
cmd_data_i  in  DATA_W  command write data
cmd_write_i  in  1  1 = write transfer, 0 = read transfer
gpu_full_i  in  1  GPU command FIFO full; no new transfer may start while high
pAddr_o  out  ADDR_W  APB address
pDataWrite_o  out  DATA_W  APB write data
pSel_o  out  1  APB select
pEnable_o  out  1  APB enable
pWrite_o  out  1  APB direction
busy_o  out  1  FIFO non-empty or FSM not IDLE
xfer_count_o  out  16  completed transfer count, wraps

Behaviour:
- Reset (async, immediate):
  - FIFO emptied; FSM to IDLE.
  - pSel_o, pEnable_o, pWrite_o, busy_o = 0.
  - pAddr_o, pDataWrite_o, xfer_count_o = 0.
  - cmd_ready_o = 1 once rst deasserts.
- FIFO:
  - Push on cmd_valid_i && cmd_ready_o.
  - Pop when the FSM enters SETUP.
  - No bypass: a command pushed at edge k is eligible for issue at edge k+1 at the earliest.
  - Push and pop on the same edge are both honoured; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
  - IDLE: if FIFO non-empty && !gpu_full_i, go to SETUP. On that edge, load pAddr_o/pWrite_o from the head entry; pDataWrite_o = head data for writes, 0 for reads. Set pSel_o=1, pEnable_o=0.
  - SETUP: always go to ACCESS after exactly 1 cycle; set pEnable_o=1. Address, data and write are held stable.
  - ACCESS: lasts exactly 1 cycle (no pReady on the slave). On exit, xfer_count_o increments (0xFFFF -> 0x0000).
    - If FIFO non-empty && !gpu_full_i: go directly to SETUP with the next entry (pSel stays 1, pEnable drops to 0). Back-to-back throughput is 1 transfer per 2 cycles.
    - Otherwise: go to IDLE with pSel=0, pEnable=0. pAddr_o/pDataWrite_o/pWrite_o hold their last values.
- gpu_full_i:
  - Sampled only at IDLE->SETUP and ACCESS->SETUP decisions.
  - A transfer already in SETUP completes through ACCESS regardless of gpu_full_i.
- Read transfers: pWrite_o=0. No read data is returned (the slave has no pRdata); they exist for protocol completeness and count in xfer_count_o.
- Latency: command accepted at edge k with FSM IDLE and gpu_full_i low -> pSel_o high after edge k+1, pEnable_o high after edge k+2.
- Reset mid-transfer: pSel/pEnable drop asynchronously. The in-flight command is discarded and not counted.
- busy_o: combinational OR of (FIFO count != 0) and (state != IDLE).

Decomposition:
- Shared package gpu_apb_pkg:
  - state enum apb_state_t {IDLE, SETUP, ACCESS}.
  - command struct apb_cmd_t {addr, data, write}.
  - APB address constants for GPU command registers, taken from the existing gpu definitions header values.
- One sub-module: gpu_cmd_fifo.
  - Synchronous FIFO of apb_cmd_t, parameter FIFO_DEPTH.
  - Ports: push/pop/full/empty/count, same clk/rst.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> all APB outputs 0 immediately, cmd_ready_o=1, busy_o=0, xfer_count_o=0.
- Single write: push addr=0x8, data=0x00FF00AA, write=1 at edge k -> pSel=1/pEnable=0 after k+1, pEnable=1 after k+2, pAddr=0x8, pDataWrite=0x00FF00AA, pWrite=1; IDLE after k+3; xfer_count=1.
- Back-to-back: push 4 writes on consecutive cycles -> FIFO full after the 4th (cmd_ready_o=0 for 1 cycle only if no pop yet); 4 transfers on cycles with pSel continuously high, pEnable toggling 0,1,0,1,...; xfer_count=4; busy_o low on the cycle after the last ACCESS.
- Backpressure: gpu_full_i=1 before issue, push 2 commands -> no pSel while full; deassert -> both issue back-to-back. Raise gpu_full_i during SETUP of cmd 1 -> cmd 1 completes, cmd 2 waits.
- Read transfer: push addr=0x10, write=0, data=0xDEADBEEF -> pWrite=0, pDataWrite=0 during SETUP/ACCESS; counted.
- Reset mid-ACCESS with 2 queued -> outputs clear immediately, FIFO empty, xfer_count=0, no further APB activity. Separately, preload xfer_count to 0xFFFF via 65535 transfers -> next completion wraps it to 0.
